// File: rtl/uart_tx_pipe.sv
// uart_tx_pipe
//   Bridges the USB CDC host->device byte stream onto an 8N1 UART TX pin.
//   Incoming bytes are queued in a small circular FIFO so that USB bursts
//   never wait on the slow serial line; a framing FSM drains the FIFO and
//   sends frames back-to-back while bytes remain.
// Ports
//   clk_48mhz   in   system clock
//   reset_n     in   asynchronous reset, active low
//   in_data     in   byte from the USB core
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept a byte
//   tx          out  serial output, idle high
//   busy        out  frame in progress or FIFO non-empty
//   fifo_level  out  FIFO occupancy, 0..FIFO_DEPTH
module uart_tx_pipe #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_48mhz,
    input  logic                        reset_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    // Clocks per bit, rounded to nearest; no fractional accumulation.
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q,  state_d;
    logic             tx_q,     tx_d;
    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             rdy_en_q;

    logic [7:0] mem_q [FIFO_DEPTH];
    logic       push;
    logic       pop;
    logic [7:0] head;

    // in_ready is a function of registers only; rdy_en_q keeps it low
    // until the first clock after reset is released.
    assign in_ready   = rdy_en_q && (level_q != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    tx_d    = shift_q[0];
                    cnt_d   = CNT_RELOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next frame when more bytes wait.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        cnt_d   = CNT_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        busy_d = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Byte storage and shift register carry data only; resetting the
    // pointers is enough to discard whatever they hold.
    always_ff @(posedge clk_48mhz) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
